// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Index width that never collapses to zero bits for a size of 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 4;
  localparam int REQ_IDX_W     = idx_w(NUM_REQ_DEF);
  localparam int BURST_CNT_W   = idx_w(MAX_BURST_DEF);
  localparam int STAT_W        = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester handshakes, FIFO write port and arbiter status.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  import fifo_arb_pkg::*;

  localparam int IDX_W = idx_w(NUM_REQ);

  // Handshake: requester i transfers req_data[i] on a clock edge where
  // req_valid[i] & req_ready[i]; once valid is raised, data stays stable
  // until that edge. fifo_w_en is a single-cycle write strobe qualified by
  // !fifo_full inside the arbiter.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_w_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic [IDX_W-1:0]              grant_id;
  logic                          busy;
  state_t                        state;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_w_en, fifo_data_in, grant_id, busy, state
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_w_en, fifo_data_in, grant_id, busy, state
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_grant, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  int idx;

  // Scan from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    winner    = '0;
    any_valid = |req;
    idx       = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N;
      if (req[idx]) begin
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of a synchronous FIFO write port.
// Optional per-requester saturating write counters when ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fifo_wr_arbiter_if.master         bus
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_wr_cnt
`endif
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] winner;
  logic             any_valid;
  logic             owner_valid;
  logic             wr;
  logic [NUM_REQ-1:0] ready;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  assign owner_valid = bus.req_valid[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wr      = 1'b0;
    ready   = '0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = BURST;
          grant_d = winner;
          last_d  = winner;
          cnt_d   = '0;
        end
      end
      BURST: begin
        ready[grant_q] = !bus.fifo_full;
        if (!owner_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!bus.fifo_full) begin
          wr = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset must suppress the handshake in the very cycle it is asserted.
    if (!rst_n) begin
      wr    = 1'b0;
      ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.fifo_w_en    = wr;
  assign bus.fifo_data_in = bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant_id     = grant_q;
  assign bus.busy         = (state_q == BURST);
  assign bus.state        = state_q;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= '0;
      end
    end else if (wr && (stat_q[grant_q] != {STAT_W{1'b1}})) begin
      stat_q[grant_q] <= stat_q[grant_q] + STAT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_wr_cnt[g*STAT_W +: STAT_W] = stat_q[g];
  end
`endif

endmodule
